freq_meter: RTL and testbench

- Gated frequency counter for the clock design. It is the measuring counterpart of the divider chain: the divider makes a known rate from CLK, and this block measures an unknown external rate against CLK.
- It counts rising edges of an asynchronous input over a gate window of exactly GATE_CYCLES CLK periods (1 s at 50 MHz by default), then latches the result as Hz.
- It supports single-shot and continuous operation, with a result-valid pulse and saturation flag.

---
 rtl/freq_meter.sv | 134 +++++++++++++
 tb/tb_freq_meter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over GATE_CYCLES
// clocks and publishes the count, with single-shot and continuous modes.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 27
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] freq,
  output logic             overflow,
  output logic             valid,
  output logic             busy
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic             sync1_q;
  logic             sync_q;
  logic             hist_q;
  logic             edge_w;
  logic             last_w;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] acc;
  logic             acc_sat;
  logic [CNT_W-1:0] freq_d;
  logic             ovf_d;
  logic             valid_d;

  assign edge_w = sync_q & ~hist_q;
  assign last_w = (gate_q == LAST);
  assign busy   = (state_q != IDLE);

  // An edge arriving with the counter already full is lost: that sets sat.
  always_comb begin
    acc     = cnt_q;
    acc_sat = sat_q;
    if (edge_w) begin
      if (&cnt_q) begin
        acc_sat = 1'b1;
      end else begin
        acc = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    freq_d  = freq;
    ovf_d   = overflow;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start | continuous) begin
          state_d = GATE;
          gate_d  = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      GATE: begin
        gate_d = gate_q + GW'(1);
        cnt_d  = acc;
        sat_d  = acc_sat;
        if (last_w) begin
          state_d = DONE;
          freq_d  = acc;
          ovf_d   = acc_sat;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (continuous) begin
          state_d = GATE;
          gate_d  = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync_q  <= sync1_q;
      hist_q  <= sync_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      gate_q   <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      freq     <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gate_q   <= gate_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      freq     <= freq_d;
      overflow <= ovf_d;
      valid    <= valid_d;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (8-bit and 4-bit counters) share
// stimulus; a scoreboard queue holds the expected result of each window.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G = 100;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       sig_in = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [7:0] freq8;
  logic       ovf8, valid8, busy8;
  logic [3:0] freq4;
  logic       ovf4, valid4, busy4;

  always #5 CLK = ~CLK;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
    .CLK(CLK), .RST(RST), .sig_in(sig_in), .start(start),
    .continuous(continuous), .freq(freq8), .overflow(ovf8),
    .valid(valid8), .busy(busy8)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .sig_in(sig_in), .start(start),
    .continuous(continuous), .freq(freq4), .overflow(ovf4),
    .valid(valid4), .busy(busy4)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Periodic source: per > 0 gives one rising edge every per cycles.
  int per = 0;
  bit lvl = 1'b0;
  int ph = 0;
  always @(posedge CLK) begin
    #1;
    if (per > 0) begin
      ph = (ph + 1) % per;
      sig_in = (ph < per / 2);
    end else begin
      sig_in = lvl;
    end
  end

  typedef struct {
    int f8;
    int o8;
    int f4;
    int o4;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  always @(negedge CLK) begin
    if (valid8) begin
      if (sbq.size() == 0) begin
        chk("spurious_valid", valid8, 0);
      end else begin
        e = sbq.pop_front();
        chk("freq8", freq8, e.f8);
        chk("ovf8", ovf8, e.o8);
        chk("freq4", freq4, e.f4);
        chk("ovf4", ovf4, e.o4);
        chk("valid4", valid4, 1);
      end
    end
  end

  task automatic wait_valid(input int maxc, output int vc);
    vc = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (valid8) begin
        vc = cyc;
        break;
      end
    end
    if (vc < 0) chk("valid_timeout", valid8, 1);
  endtask

  task automatic pulse_start(output int k);
    @(posedge CLK);
    #1 start = 1'b1;
    k = cyc;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  typedef struct {
    int per;
    bit lvl;
    exp_t ex;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int k, vc, v1, v2, v3, v4;
    exp_t x;

    tbl[0] = '{per: 10, lvl: 1'b0, ex: '{10, 0, 10, 0}};
    tbl[1] = '{per: 0,  lvl: 1'b0, ex: '{0, 0, 0, 0}};
    tbl[2] = '{per: 0,  lvl: 1'b1, ex: '{0, 0, 0, 0}};
    tbl[3] = '{per: 4,  lvl: 1'b0, ex: '{25, 0, 15, 1}};
    tbl[4] = '{per: 20, lvl: 1'b0, ex: '{5, 0, 5, 0}};
    tbl[5] = '{per: 5,  lvl: 1'b0, ex: '{20, 0, 15, 1}};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_freq8", freq8, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_valid8", valid8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_busy4", busy4, 0);
    RST = 1'b1;

    // Single-shot windows, latency measured from the drive edge.
    for (int i = 0; i < 6; i++) begin
      per = tbl[i].per;
      lvl = tbl[i].lvl;
      repeat (8) @(posedge CLK);
      sbq.push_back(tbl[i].ex);
      pulse_start(k);
      wait_valid(G + 10, vc);
      chk("latency", vc - k, G + 1);
      @(negedge CLK);
      chk("busy_after", busy8, 0);
      chk("valid_drop", valid8, 0);
    end

    // Continuous mode, then drop continuous mid-window.
    per = 5;
    repeat (8) @(posedge CLK);
    x = '{20, 0, 15, 1};
    repeat (4) sbq.push_back(x);
    @(posedge CLK);
    #1 continuous = 1'b1;
    wait_valid(G + 10, v1);
    wait_valid(G + 10, v2);
    chk("cont_period1", v2 - v1, G + 1);
    wait_valid(G + 10, v3);
    chk("cont_period2", v3 - v2, G + 1);
    repeat (40) @(posedge CLK);
    #1 continuous = 1'b0;
    wait_valid(G + 10, v4);
    chk("cont_last", v4 - v3, G + 1);
    @(negedge CLK);
    chk("cont_idle", busy8, 0);
    repeat (150) @(posedge CLK);
    chk("cont_drained", sbq.size(), 0);

    // start re-pulsed during GATE must not queue a second window.
    per = 10;
    repeat (8) @(posedge CLK);
    sbq.push_back('{10, 0, 10, 0});
    pulse_start(k);
    repeat (30) @(posedge CLK);
    pulse_start(v1);
    chk("busy_mid", busy8, 1);
    wait_valid(G + 10, vc);
    chk("repulse_latency", vc - k, G + 1);
    repeat (150) @(posedge CLK);
    #1;
    chk("repulse_idle", busy8, 0);
    chk("repulse_drained", sbq.size(), 0);

    // Reset in the middle of a window: nothing published.
    pulse_start(k);
    repeat (49) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("mrst_freq8", freq8, 0);
    chk("mrst_freq4", freq4, 0);
    chk("mrst_ovf4", ovf4, 0);
    chk("mrst_valid", valid8, 0);
    chk("mrst_busy", busy8, 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    repeat (150) @(posedge CLK);
    #1;
    chk("mrst_idle", busy8, 0);
    sbq.push_back('{10, 0, 10, 0});
    pulse_start(k);
    wait_valid(G + 10, vc);
    chk("mrst_restart_latency", vc - k, G + 1);
    repeat (20) @(posedge CLK);
    chk("final_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
